// File: rtl/stream_demux_1xn.sv
// One-word registered 1-to-N stream demultiplexer; words with an out-of-range select are accepted and dropped.
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN enables the saturating 8-bit drop counter.
module stream_demux_1xn #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SELW-1:0]       in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [CH-1:0]         out_valid,
  input  logic [CH-1:0]         out_ready,
  output logic [WIDTH*CH-1:0]   out_data,
  output logic [7:0]            drop_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [SELW:0] CH_LIM = (SELW+1)'(CH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [SELW-1:0]   hold_sel_q, hold_sel_d;

  logic sel_ready;
  logic in_range;
  logic up_xfer;
  logic dn_xfer;

  // in_ready depends only on registered state and out_ready, never on the upstream word
  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (hold_sel_q == SELW'(i)) sel_ready = out_ready[i];
    end
    in_ready = (state_q == S_EMPTY) ? 1'b1 : sel_ready;
    in_range = ({1'b0, in_sel} < CH_LIM);
    up_xfer  = in_valid & in_ready;
    dn_xfer  = (state_q == S_FULL) & sel_ready;
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    case (state_q)
      S_EMPTY: begin
        if (up_xfer && in_range) begin
          hold_data_d = in_data;
          hold_sel_d  = in_sel;
          state_d     = S_FULL;
        end
      end
      S_FULL: begin
        if (dn_xfer) begin
          if (up_xfer && in_range) begin
            hold_data_d = in_data;
            hold_sel_d  = in_sel;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      hold_data_q <= '0;
      hold_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (state_q == S_FULL) begin
      for (int i = 0; i < CH; i++) begin
        if (hold_sel_q == SELW'(i)) begin
          out_valid[i]                = 1'b1;
          out_data[i*WIDTH +: WIDTH]  = hold_data_q;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (up_xfer && !in_range && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Scoreboard bench for stream_demux_1xn: a 4-channel instance for data flow, a 3-channel instance for drops.
module tb_stream_demux_1xn;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;

  logic        iv;
  logic        ir;
  logic [1:0]  isel;
  logic [7:0]  idata;
  logic [3:0]  ov;
  logic [3:0]  ordy;
  logic [31:0] od;
  logic [7:0]  dc;

  logic        iv3;
  logic        ir3;
  logic [1:0]  isel3;
  logic [7:0]  idata3;
  logic [2:0]  ov3;
  logic [2:0]  ordy3;
  logic [23:0] od3;
  logic [7:0]  dc3;

  logic        drop_phase;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.WIDTH(8), .CH(4), .SELW(2)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .in_sel(isel), .in_data(idata),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .drop_cnt(dc)
  );

  stream_demux_1xn #(.WIDTH(8), .CH(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3), .in_sel(isel3), .in_data(idata3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .drop_cnt(dc3)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int exp_drop(input int n);
    if (!DROP_EN) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic push_exp(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    int k;
    iv = 1'b1; isel = sel; idata = d;
    k = 0;
    @(negedge clk);
    while (!ir && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("ready_timeout", ir, 1);
    step();
    push_exp(sel, d);
    iv = 1'b0;
  endtask

  // Monitor for the 4-channel instance: pop and compare on each downstream transfer.
  always @(negedge clk) begin
    if (!rst) begin
      logic [31:0] vmask;
      vmask = '0;
      for (int i = 0; i < 4; i++) vmask[i*8 +: 8] = {8{ov[i]}};
      chk("idle_lanes_zero", od & ~vmask, 0);
      chk("onehot_valid", ($countones(ov) > 1), 0);
      for (int i = 0; i < 4; i++) begin
        if (ov[i] && ordy[i]) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", exp_q.size(), 1);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("xfer_ch", i, e.ch);
            chk("xfer_data", od[i*8 +: 8], e.data);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && drop_phase) begin
      chk("drop_no_valid", ov3, 0);
      chk("drop_in_ready", ir3, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv = 1'b0; isel = '0; idata = '0; ordy = 4'b1111;
    iv3 = 1'b0; isel3 = '0; idata3 = '0; ordy3 = 3'b111;
    drop_phase = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", ov, 0);
    chk("reset_out_data", od, 0);
    chk("reset_in_ready", ir, 1);
    chk("reset_drop_cnt", dc, 0);
    step();

    // Single word on the top channel
    send(2'd3, 8'hA5);
    @(negedge clk);
    chk("a5_out_valid", ov, 4'b1000);
    chk("a5_out_data", od, 32'hA500_0000);
    step();

    // Back-to-back stream over channels 0,1,2
    for (int j = 0; j < 3; j++) begin
      iv = 1'b1; isel = 2'(j); idata = 8'(j + 1);
      @(negedge clk);
      chk("stream_in_ready", ir, 1);
      if (j > 0) chk("stream_out_valid", ov, (1 << (j - 1)));
      step();
      push_exp(j, 8'(j + 1));
    end
    iv = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", ov, 4'b0100);
    chk("stream_last_data", od, 32'h0003_0000);
    step(); step();

    // Backpressure on channel 1 while the next word waits upstream
    ordy = 4'b1101;
    send(2'd1, 8'h3C);
    iv = 1'b1; isel = 2'd0; idata = 8'h55;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_in_ready", ir, 0);
      chk("stall_out_valid", ov, 4'b0010);
      chk("stall_out_data", od, 32'h0000_3C00);
      step();
    end
    ordy = 4'b1111;
    @(negedge clk);
    chk("release_in_ready", ir, 1);
    step();
    push_exp(0, 8'h55);
    iv = 1'b0;
    @(negedge clk);
    chk("after_release_valid", ov, 4'b0001);
    chk("after_release_data", od, 32'h0000_0055);
    step(); step();

    // Reset while FULL on channel 2, with an upstream word offered during reset
    ordy = 4'b0000;
    send(2'd2, 8'h77);
    @(negedge clk);
    chk("full_ch2_valid", ov, 4'b0100);
    step();
    rst = 1'b1;
    ordy = 4'b1111;
    iv = 1'b1; isel = 2'd0; idata = 8'h99;
    exp_q.delete();
    step();
    rst = 1'b0;
    iv = 1'b0;
    @(negedge clk);
    chk("rst_full_out_valid", ov, 0);
    chk("rst_full_out_data", od, 0);
    chk("rst_full_in_ready", ir, 1);
    chk("rst_full_drop_cnt", dc, 0);
    step();
    @(negedge clk);
    chk("rst_upstream_ignored", ov, 0);
    step();

    // Out-of-range drops on the 3-channel instance
    drop_phase = 1'b1;
    iv3 = 1'b1; isel3 = 2'd3; idata3 = 8'hEE;
    repeat (3) step();
    iv3 = 1'b0;
    @(negedge clk);
    chk("drop_cnt_3", dc3, exp_drop(3));
    step();
    iv3 = 1'b1;
    repeat (251) step();
    iv3 = 1'b0;
    @(negedge clk);
    chk("drop_cnt_254", dc3, exp_drop(254));
    step();
    iv3 = 1'b1;
    step();
    iv3 = 1'b0;
    @(negedge clk);
    chk("drop_cnt_255", dc3, exp_drop(255));
    step();
    iv3 = 1'b1;
    repeat (3) step();
    iv3 = 1'b0;
    @(negedge clk);
    chk("drop_cnt_sat", dc3, exp_drop(258));
    step();
    drop_phase = 1'b0;

    // An in-range word still works on the 3-channel instance and is not counted
    iv3 = 1'b1; isel3 = 2'd1; idata3 = 8'h42;
    step();
    iv3 = 1'b0;
    @(negedge clk);
    chk("ch3_inrange_valid", ov3, 3'b010);
    chk("ch3_inrange_data", od3, 24'h00_4200);
    chk("ch3_inrange_drop_cnt", dc3, exp_drop(258));
    step(); step();

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("final_drop_cnt_4ch", dc, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_1xn.md
STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter CH, default 4, number of output channels (2..16).
REQ-003 Parameter SELW, default 2, select width; SHALL satisfy 2**SELW >= CH.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts the upstream word this cycle.
REQ-008 in_sel  input  SELW  destination channel index.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  CH  per-channel valid; bit i belongs to channel i.
REQ-011 out_ready  input  CH  per-channel downstream ready.
REQ-012 out_data  output  WIDTH*CH  flat payload bus; lane i is bits [i*WIDTH +: WIDTH].
REQ-013 drop_cnt  output  8  count of discarded out-of-range words.

Function
REQ-014 Upstream transfer occurs on a cycle with in_valid=1 and in_ready=1; downstream transfer on channel i occurs with out_valid[i]=1 and out_ready[i]=1.
REQ-015 The block SHALL hold one registered word (hold_data, hold_sel) under a 2-state FSM: EMPTY, FULL.
REQ-016 EMPTY: in_ready=1; an upstream transfer with in_sel<CH loads the hold register and moves to FULL.
REQ-017 FULL: out_valid[hold_sel]=1, all other out_valid bits 0; in_ready = out_ready[hold_sel].
REQ-018 FULL with downstream transfer and simultaneous in-range upstream transfer: the new word SHALL be loaded and the state SHALL stay FULL (back-to-back, 1 word/cycle).
REQ-019 FULL with downstream transfer and no in-range upstream transfer: the state SHALL move to EMPTY.
REQ-020 FULL without downstream transfer: the hold register and state SHALL be unchanged; in_ready=0.
REQ-021 Latency: a word accepted at edge N SHALL be visible on its channel from cycle N+1.
REQ-022 out_data lane hold_sel SHALL carry hold_data when FULL; every other lane, and all lanes when EMPTY, SHALL be 0.
REQ-023 in_ready SHALL NOT depend combinationally on in_valid, in_sel or in_data.
REQ-024 Out-of-range words (in_sel>=CH) SHALL be accepted per the normal in_ready rule and discarded; they SHALL NOT alter the hold register or out_valid.
REQ-025 Words SHALL be delivered in acceptance order; none SHALL be duplicated or lost, except per REQ-024.

Reset
REQ-026 While rst=1 at a clock edge: state=EMPTY, hold_data=0, hold_sel=0, drop_cnt=0.
REQ-027 During and after reset: out_valid=0, out_data=0, in_ready=1 from the first cycle after rst deasserts.
REQ-028 Reset asserted while FULL SHALL discard the held word without a downstream transfer.
REQ-029 An upstream transfer on a cycle with rst=1 SHALL be ignored.

Configuration
REQ-030 Macro STREAM_DEMUX_DROP_CNT_EN. Defined: drop_cnt SHALL increment by 1 on each out-of-range upstream transfer and saturate at 255.
REQ-031 Not defined: drop_cnt SHALL be tied to 0 and no counter logic SHALL be present; all other behaviour is identical.

Verification
REQ-032 Reset while FULL on channel 2 -> next cycle out_valid=0000, out_data=0, in_ready=1, drop_cnt=0.
REQ-033 Send 0xA5 with sel=3 and out_ready=1111 -> one cycle later out_valid=1000, lane 3=0xA5, lanes 0-2=0.
REQ-034 Stream 0x01,0x02,0x03 with sel=0,1,2 on consecutive cycles, all out_ready=1 -> one word per cycle on channels 0,1,2 in order, in_ready held at 1.
REQ-035 Hold 0x3C on sel=1 with out_ready[1]=0 for 3 cycles while in_valid=1 and out_ready of other channels=1 -> in_ready=0 and out_valid=0010 for all 3 cycles; after out_ready[1]=1, 0x3C transfers exactly once.
REQ-036 CH=3, SELW=2, macro defined: send sel=3 three times -> no out_valid asserted, drop_cnt=3; 258 drops -> drop_cnt=255.
REQ-037 Same as REQ-036 without the macro -> drop_cnt=0 throughout, no out_valid asserted.
